// File: rtl/div_seq_pkg.sv
// Shared definitions for the execute-stage divide sequencer.
// Holds the FSM state encodings, result width and the EX op codes that select DIV/DIVU.
package div_seq_pkg;

    localparam int REG_DATA_WIDTH   = 32;
    localparam int DIV_RESULT_WIDTH = 2 * REG_DATA_WIDTH;

    localparam logic [5:0] EXE_OP_DIV  = 6'h1A;
    localparam logic [5:0] EXE_OP_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_DIVZERO = 2'b01,
        S_RUN     = 2'b10,
        S_DONE    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage (master) and the divide sequencer (slave).
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
);
    logic                      start_in;
    logic                      signed_in;
    logic                      annul_in;
    logic [DATA_WIDTH-1:0]     dividend_in;
    logic [DATA_WIDTH-1:0]     divisor_in;
    logic [2*DATA_WIDTH-1:0]   result_out;
    logic                      ready_out;
    logic                      stall_req_out;

    modport master (
        output start_in, signed_in, annul_in, dividend_in, divisor_in,
        input  result_out, ready_out, stall_req_out
    );

    modport slave (
        input  start_in, signed_in, annul_in, dividend_in, divisor_in,
        output result_out, ready_out, stall_req_out
    );
endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring divide step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[DATA_WIDTH]) begin
            rem_next = diff[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: latches operand magnitudes, runs one restoring step per
// cycle, sign-corrects and presents {remainder, quotient} until EX drops its request.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input logic        clk,
    input logic        rst_n,
    div_seq_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    div_state_t              state, state_nx;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   rem, quo, dvsr;
    logic [DATA_WIDTH-1:0]   rem_nx, quo_nx;
    logic [DATA_WIDTH-1:0]   fix_rem, fix_quo;
    logic                    neg_quo, neg_rem;
    logic                    ready;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    accept, last_step, divisor_zero;
    logic                    dividend_neg, divisor_neg;

    assign accept       = bus.start_in & ~bus.annul_in;
    assign last_step    = (cnt == CW'(DATA_WIDTH - 1));
    assign divisor_zero = (bus.divisor_in == '0);
    assign dividend_neg = bus.signed_in & bus.dividend_in[DATA_WIDTH-1];
    assign divisor_neg  = bus.signed_in & bus.divisor_in[DATA_WIDTH-1];

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Sign flags are already gated by signed_in at latch time.
    assign fix_quo = neg_quo ? -quo_nx : quo_nx;
    assign fix_rem = neg_rem ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.annul_in) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept) state_nx = divisor_zero ? S_DIVZERO : S_RUN;
                S_DIVZERO: state_nx = S_DONE;
                S_RUN:     if (last_step) state_nx = S_DONE;
                S_DONE:    if (!bus.start_in) state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            ready   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (divisor_zero) begin
                            rem <= bus.dividend_in;
                            quo <= '1;
                        end else begin
                            rem     <= '0;
                            quo     <= dividend_neg ? -bus.dividend_in : bus.dividend_in;
                            dvsr    <= divisor_neg ? -bus.divisor_in : bus.divisor_in;
                            neg_quo <= dividend_neg ^ divisor_neg;
                            neg_rem <= dividend_neg;
                        end
                    end
                end
                S_RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        ready  <= 1'b1;
                        result <= {fix_rem, fix_quo};
                    end
                end
                S_DIVZERO: begin
                    ready  <= 1'b1;
                    result <= {rem, quo};
                end
                S_DONE: begin
                    if (!bus.start_in) begin
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: ;
            endcase
            // Annul wins over completion and over a fresh start.
            if (bus.annul_in) begin
                ready  <= 1'b0;
                result <= '0;
            end
        end
    end

    assign bus.result_out    = result;
    assign bus.ready_out     = ready;
    assign bus.stall_req_out = bus.start_in & ~ready & ~bus.annul_in;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected {rem, quo} queued at launch, compared when ready_out rises.
module tb_div_seq;
    import div_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [DIV_RESULT_WIDTH-1:0] sb_q[$];

    div_seq_if #(.DATA_WIDTH(REG_DATA_WIDTH)) bus ();

    div_seq #(.DATA_WIDTH(REG_DATA_WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge; that cycle is cycle 0 of the operation.
    task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit track);
        bus.start_in    = 1'b1;
        bus.signed_in   = (op == EXE_OP_DIV);
        bus.dividend_in = a;
        bus.divisor_in  = b;
        if (track) sb_q.push_back(model(op == EXE_OP_DIV, a, b));
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int hold);
        int lat = 0;
        int stall_cyc = 0;
        logic [63:0] exp;
        logic [63:0] res;
        forever begin
            @(negedge clk);
            if (bus.ready_out) break;
            if (bus.stall_req_out) stall_cyc++;
            lat++;
            if (lat > 100) begin
                chk({tag, "_timeout"}, 64'(lat), 64'(exp_lat));
                bus.start_in = 1'b0;
                return;
            end
        end
        // Junk operand values must not leak into the held result.
        bus.dividend_in = $urandom;
        bus.divisor_in  = $urandom;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stall_cyc), 64'(exp_lat));
        chk({tag, "_stall_at_ready"}, 64'(bus.stall_req_out), 64'(0));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
            return;
        end
        exp = sb_q.pop_front();
        res = bus.result_out;
        chk({tag, "_result"}, res, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_ready"}, 64'(bus.ready_out), 64'(1));
            chk({tag, "_hold_result"}, bus.result_out, exp);
        end
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_ready"}, 64'(bus.ready_out), 64'(0));
        chk({tag, "_drop_result"}, bus.result_out, 64'(0));
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.ready_out) seen++;
        end
        chk({tag, "_ready_never"}, 64'(seen), 64'(0));
        chk({tag, "_result_zero"}, bus.result_out, 64'(0));
    endtask

    initial begin
        bus.start_in    = 1'b1;
        bus.signed_in   = 1'b0;
        bus.annul_in    = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        #3;
        chk("rst_ready", 64'(bus.ready_out), 64'(0));
        chk("rst_result", bus.result_out, 64'(0));
        chk("rst_stall", 64'(bus.stall_req_out), 64'(1));
        bus.start_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(EXE_OP_DIVU, 32'd7, 32'd2, 1);
        wait_result("udiv_7_2", 33, 0);

        launch(EXE_OP_DIV, 32'hFFFF_FFF9, 32'h2, 1);
        wait_result("sdiv_m7_2", 33, 0);

        launch(EXE_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_result("sdiv_ovf", 33, 0);

        launch(EXE_OP_DIV, 32'd7, 32'hFFFF_FFFE, 1);
        wait_result("sdiv_7_m2", 33, 0);

        launch(EXE_OP_DIVU, 32'h1234_5678, 32'h0, 1);
        wait_result("divzero", 2, 0);

        // Annul at RUN cycle 10 with start still high.
        launch(EXE_OP_DIVU, 32'hDEAD_BEEF, 32'd3, 0);
        repeat (10) @(posedge clk);
        #1 bus.annul_in = 1'b1;
        @(negedge clk);
        chk("annul_stall", 64'(bus.stall_req_out), 64'(0));
        @(posedge clk);
        #1;
        bus.annul_in = 1'b0;
        bus.start_in = 1'b0;
        idle_watch("annul", 40);
        @(posedge clk);
        #1;
        launch(EXE_OP_DIVU, 32'd100, 32'd7, 1);
        wait_result("after_annul", 33, 0);

        // Asynchronous reset at RUN cycle 5, between clock edges.
        launch(EXE_OP_DIVU, 32'hCAFE_F00D, 32'd9, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.start_in = 1'b0;
        #1;
        chk("midrst_ready", 64'(bus.ready_out), 64'(0));
        chk("midrst_result", bus.result_out, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch("after_rst", 40);
        @(posedge clk);
        #1;
        launch(EXE_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1);
        wait_result("udiv_ffff_10", 33, 0);

        // Handshake: hold past ready, drop, then restart in the very next cycle.
        launch(EXE_OP_DIVU, 32'd5, 32'd9, 1);
        wait_result("hold3", 33, 3);
        launch(EXE_OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1);
        wait_result("restart", 33, 0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i == 3) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
            launch((i % 2 == 0) ? EXE_OP_DIV : EXE_OP_DIVU, a, b, 1);
            wait_result($sformatf("rand%0d", i), (b == 32'h0) ? 2 : 33, 1);
        end

        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
